mdio_phy_responder: RTL and testbench
=====================================

MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 Parameter: PHY_ADDR, 5'd1, PHY address this responder answers to.
REQ-002 Port: clk  input  1  MDC from the MDIO controller; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: mdio_out  input  1  serial frame bit driven by the controller.
REQ-005 Port: mdio_oe  input  1  controller output enable; 1 = mdio_out valid.
REQ-006 Port: mdio_in  output  1  serial read data returned to the controller; 1 when not driving.
REQ-007 Port: phy_oe  output  1  1 while the responder drives mdio_in.
REQ-008 Port: reg_addr  output  5  register address decoded from the REGAD field.
REQ-009 Port: reg_wr_data  output  16  write data decoded from the DATA field.
REQ-010 Port: reg_wr_en  output  1  one-cycle write strobe to the register file.
REQ-011 Port: reg_rd_en  output  1  one-cycle read strobe to the register file.
REQ-012 Port: reg_rd_data  input  16  register file read data, valid one cycle after reg_rd_en.
REQ-013 Port: busy  output  1  1 from ST detection until the frame ends or aborts.

Function
REQ-014 Frame is 32 bits MSB first, f1..f32 sampled at edges E1..E32: ST f1-2 (01), OP f3-4 (01 write, 10 read), PHYAD f5-9, REGAD f10-14, TA f15-16, DATA f17-32.
REQ-015 States: IDLE, START, HEADER, TA, WR_DATA, RD_DATA, SKIP.
REQ-016 IDLE: mdio_oe=1 and mdio_out=0 -> START; else stay.
REQ-017 START: mdio_out=1 -> HEADER (busy=1); mdio_out=0 -> stay in START.
REQ-018 HEADER shifts 12 bits (OP, PHYAD, REGAD); at E14, reg_addr is loaded from REGAD.
REQ-019 At E14, PHYAD != PHY_ADDR or OP in {00,11} -> SKIP; SKIP counts to E32 with no strobes and no drive, then -> IDLE.
REQ-020 Read: reg_rd_en=1 for exactly the cycle after E14; at E15, reg_rd_data is captured into the shift register.
REQ-021 Read: after E15, phy_oe=1 and mdio_in=0 (TA bit 2); after E16..E31, mdio_in = data[15]..data[0]; after E32, phy_oe=0, mdio_in=1, and -> IDLE.
REQ-022 Write: TA bits are sampled and ignored; f17-32 are shifted in. After E32, reg_wr_data is loaded and reg_wr_en=1 for one cycle, then -> IDLE.
REQ-023 Abort: mdio_oe=0 during HEADER or WR_DATA -> IDLE immediately; no reg_wr_en; reg_wr_data unchanged.
REQ-024 mdio_oe is ignored during TA and RD_DATA; a controller collision is not detected.
REQ-025 The next frame is accepted starting at the edge after return to IDLE (back-to-back frames allowed).
REQ-026 reg_rd_en and reg_wr_en are never high in the same cycle; neither strobe lasts more than one cycle.
REQ-027 All outputs are registered; none is combinational from mdio_out.

Reset
REQ-028 reset=0 forces immediately: state IDLE, mdio_in=1, phy_oe=0, reg_addr=0, reg_wr_data=0, reg_wr_en=0, reg_rd_en=0, busy=0, and the bit counter and shift register cleared.
REQ-029 Reset asserted mid-read releases phy_oe asynchronously; reset mid-write produces no reg_wr_en.
REQ-030 After reset deasserts, the first frame is accepted normally.

Configuration
REQ-031 Macro MDIO_PREAMBLE_EN: when defined, IDLE -> START requires at least 32 consecutive samples of mdio_out=1 with mdio_oe=1 before the 0 start bit. A 5-bit saturating counter plus flag is used, cleared on any 0 or mdio_oe=0.
REQ-032 Without MDIO_PREAMBLE_EN, ST is accepted directly from IDLE per REQ-016 and no preamble logic is compiled in.

Verification
REQ-033 PHY_ADDR=1, write frame 32'b01_01_00001_00011_10_1010010111000011 -> after E32, reg_wr_en one cycle with reg_addr=3 and reg_wr_data=16'hA5C3; phy_oe stays 0.
REQ-034 Read frame 32'b01_10_00001_00101 + TA released, reg_rd_data=16'hBEEF -> reg_rd_en one cycle after E14 with reg_addr=5; mdio_in = 0 then 1011111011101111 at E16..E32; phy_oe=0 after E32.
REQ-035 Write frame with PHYAD=5'd2 -> no reg_wr_en, phy_oe=0 throughout, busy drops after E32, and the next valid frame is accepted.
REQ-036 OP=00 frame, then a read frame back-to-back -> first frame ignored, read returns correct data.
REQ-037 Reset asserted at E20 of a read -> phy_oe=0 and mdio_in=1 immediately; a subsequent write frame completes correctly.
REQ-038 With MDIO_PREAMBLE_EN defined: write frame preceded by 31 ones -> ignored; preceded by 32 ones -> reg_wr_en asserted.

Source files
------------

// File: rtl/mdio_phy_responder_if.sv
// MDIO PHY responder bus: the serial management pins plus the register-file
// side. The responder uses the slave modport; the controller/register-file side uses master.
interface mdio_phy_responder_if;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic        phy_oe;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data;
  logic        busy;

  modport slave (
    input  mdio_out, mdio_oe, reg_rd_data,
    output mdio_in, phy_oe, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, busy
  );

  modport master (
    output mdio_out, mdio_oe, reg_rd_data,
    input  mdio_in, phy_oe, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, busy
  );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side frame responder: decodes read/write frames on MDC.
// Optional MDIO_PREAMBLE_EN demands 32 preamble ones before the start bit.
module mdio_phy_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  mdio_phy_responder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, START, HEADER, TA, WR_DATA, RD_DATA, SKIP} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [15:0] shreg, shreg_n;
  logic        is_rd, is_rd_n;
  logic        mdio_in_q, mdio_in_n;
  logic        phy_oe_q, phy_oe_n;
  logic [4:0]  addr_q, addr_n;
  logic [15:0] wdata_q, wdata_n;
  logic        wr_en_q, wr_en_n;
  logic        rd_en_q, rd_en_n;
  logic        busy_q, busy_n;
  logic        start_ok;

  // cnt holds the number of the last edge consumed, so this is the current edge
  logic [5:0]  edge_num;
  logic [11:0] hdr;
  assign edge_num = {1'b0, cnt} + 6'd1;
  assign hdr      = {shreg[10:0], bus.mdio_out};

`ifdef MDIO_PREAMBLE_EN
  logic [4:0] pre_cnt, pre_cnt_n;
  logic       pre_ok, pre_ok_n;

  always_comb begin
    pre_cnt_n = '0;
    pre_ok_n  = 1'b0;
    if (state == IDLE && bus.mdio_oe && bus.mdio_out) begin
      pre_cnt_n = pre_cnt;
      pre_ok_n  = pre_ok;
      if (pre_cnt == 5'd31) pre_ok_n = 1'b1;
      else                  pre_cnt_n = pre_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      pre_ok  <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt_n;
      pre_ok  <= pre_ok_n;
    end
  end

  assign start_ok = pre_ok;
`else
  assign start_ok = 1'b1;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    is_rd_n   = is_rd;
    mdio_in_n = mdio_in_q;
    phy_oe_n  = phy_oe_q;
    addr_n    = addr_q;
    wdata_n   = wdata_q;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.mdio_oe && !bus.mdio_out && start_ok) state_n = START;
      end
      START: begin
        if (!bus.mdio_oe) state_n = IDLE;
        else if (bus.mdio_out) begin
          state_n = HEADER;
          cnt_n   = 5'd2;
        end
      end
      HEADER: begin
        if (!bus.mdio_oe) state_n = IDLE;
        else begin
          shreg_n = {shreg[14:0], bus.mdio_out};
          cnt_n   = edge_num[4:0];
          if (edge_num == 6'd14) begin
            addr_n = hdr[4:0];
            if (hdr[9:5] != PHY_ADDR || hdr[11:10] == 2'b00 || hdr[11:10] == 2'b11)
              state_n = SKIP;
            else begin
              state_n = TA;
              is_rd_n = (hdr[11:10] == 2'b10);
              rd_en_n = (hdr[11:10] == 2'b10);
            end
          end
        end
      end
      TA: begin
        // Controller enable is not checked here: it releases the line on reads
        cnt_n = edge_num[4:0];
        if (edge_num == 6'd15) begin
          if (is_rd) begin
            shreg_n   = bus.reg_rd_data;
            phy_oe_n  = 1'b1;
            mdio_in_n = 1'b0;
          end
        end else if (is_rd) begin
          mdio_in_n = shreg[15];
          shreg_n   = {shreg[14:0], 1'b0};
          state_n   = RD_DATA;
        end else begin
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        if (!bus.mdio_oe) state_n = IDLE;
        else begin
          shreg_n = {shreg[14:0], bus.mdio_out};
          cnt_n   = edge_num[4:0];
          if (edge_num == 6'd32) begin
            wdata_n = {shreg[14:0], bus.mdio_out};
            wr_en_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      RD_DATA: begin
        cnt_n = edge_num[4:0];
        if (edge_num == 6'd32) begin
          phy_oe_n  = 1'b0;
          mdio_in_n = 1'b1;
          state_n   = IDLE;
        end else begin
          mdio_in_n = shreg[15];
          shreg_n   = {shreg[14:0], 1'b0};
        end
      end
      SKIP: begin
        cnt_n = edge_num[4:0];
        if (edge_num == 6'd32) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) cnt_n = '0;
    busy_n = (state_n != IDLE) && (state_n != START);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      is_rd     <= 1'b0;
      mdio_in_q <= 1'b1;
      phy_oe_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      is_rd     <= is_rd_n;
      mdio_in_q <= mdio_in_n;
      phy_oe_q  <= phy_oe_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      wr_en_q   <= wr_en_n;
      rd_en_q   <= rd_en_n;
      busy_q    <= busy_n;
    end
  end

  assign bus.mdio_in     = mdio_in_q;
  assign bus.phy_oe      = phy_oe_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: frames driven bit by bit on MDC,
// per-edge output snapshots compared against hand-computed values.
module tb_mdio_phy_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdio_phy_responder_if bus();
  mdio_phy_responder #(.PHY_ADDR(5'd1)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
  localparam int PRE_B2B = 32;
`else
  localparam int PRE = 2;
  localparam int PRE_B2B = 0;
`endif

  int errors = 0;
  int checks = 0;

  logic [32:1] s_wr_en, s_rd_en, s_phy_oe, s_mdio_in, s_busy;
  logic [4:0]  s_addr  [1:32];
  logic [15:0] s_wdata [1:32];
  logic [15:0] rd_word;

  task automatic send_bit(input logic oe, input logic b);
    @(negedge clk);
    bus.mdio_oe  = oe;
    bus.mdio_out = b;
    @(posedge clk);
    #1;
  endtask

  // Drives pre idle ones, then frame bits f1..f(n_edges); oe low from edge off_from on.
  task automatic run_frame(input logic [31:0] bits, input int pre, input int off_from, input int n_edges);
    s_wr_en = '0; s_rd_en = '0; s_phy_oe = '0; s_mdio_in = '0; s_busy = '0;
    for (int k = 1; k <= 32; k++) begin
      s_addr[k] = '0;
      s_wdata[k] = '0;
    end
    for (int i = 0; i < pre; i++) send_bit(1'b1, 1'b1);
    for (int k = 1; k <= n_edges; k++) begin
      send_bit((k < off_from), bits[32-k]);
      s_wr_en[k]   = bus.reg_wr_en;
      s_rd_en[k]   = bus.reg_rd_en;
      s_phy_oe[k]  = bus.phy_oe;
      s_mdio_in[k] = bus.mdio_in;
      s_busy[k]    = bus.busy;
      s_addr[k]    = bus.reg_addr;
      s_wdata[k]   = bus.reg_wr_data;
    end
  endtask

  task automatic collect_rd_word();
    rd_word = '0;
    for (int k = 16; k <= 31; k++) rd_word = {rd_word[14:0], s_mdio_in[k]};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.mdio_oe = 1'b0; bus.mdio_out = 1'b1; bus.reg_rd_data = '0;
    #12;
    checks++; if (bus.mdio_in !== 1'b1) begin errors++; $display("FAIL rst_mdio_in got %b exp 1", bus.mdio_in); end
    checks++; if (bus.phy_oe !== 1'b0) begin errors++; $display("FAIL rst_phy_oe got %b exp 0", bus.phy_oe); end
    checks++; if (bus.reg_addr !== 5'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.reg_addr); end
    checks++; if (bus.reg_wr_data !== 16'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus.reg_wr_data); end
    checks++; if (bus.reg_wr_en !== 1'b0 || bus.reg_rd_en !== 1'b0) begin errors++; $display("FAIL rst_strobes got %b%b exp 00", bus.reg_wr_en, bus.reg_rd_en); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_write();
    run_frame(32'b01_01_00001_00011_10_1010010111000011, PRE, 33, 32);
    checks++; if (s_busy[1] !== 1'b0) begin errors++; $display("FAIL wr_busy_e1 got %b exp 0", s_busy[1]); end
    checks++; if (s_busy[2] !== 1'b1) begin errors++; $display("FAIL wr_busy_e2 got %b exp 1", s_busy[2]); end
    checks++; if (s_addr[14] !== 5'd3) begin errors++; $display("FAIL wr_addr got %h exp 3", s_addr[14]); end
    checks++; if (s_wr_en[31:1] !== 31'd0) begin errors++; $display("FAIL wr_en_early got %h exp 0", s_wr_en[31:1]); end
    checks++; if (s_wr_en[32] !== 1'b1) begin errors++; $display("FAIL wr_en_e32 got %b exp 1", s_wr_en[32]); end
    checks++; if (s_wdata[31] !== 16'h0) begin errors++; $display("FAIL wr_data_early got %h exp 0", s_wdata[31]); end
    checks++; if (s_wdata[32] !== 16'hA5C3) begin errors++; $display("FAIL wr_data got %h exp a5c3", s_wdata[32]); end
    checks++; if (s_phy_oe !== 32'd0 || s_rd_en !== 32'd0) begin errors++; $display("FAIL wr_no_drive got oe=%h rd=%h exp 0", s_phy_oe, s_rd_en); end
    send_bit(1'b1, 1'b1);
    checks++; if (bus.reg_wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL wr_after got wr_en=%b busy=%b exp 0 0", bus.reg_wr_en, bus.busy); end
  endtask

  task automatic test_read();
    bus.reg_rd_data = 16'hBEEF;
    run_frame({2'b01, 2'b10, 5'd1, 5'd5, 18'h3FFFF}, PRE, 15, 32);
    collect_rd_word();
    checks++; if (s_rd_en[14] !== 1'b1 || $countones(s_rd_en) != 1) begin errors++; $display("FAIL rd_en got %h exp only edge14", s_rd_en); end
    checks++; if (s_addr[14] !== 5'd5) begin errors++; $display("FAIL rd_addr got %h exp 5", s_addr[14]); end
    checks++; if (s_phy_oe[14] !== 1'b0 || s_mdio_in[14] !== 1'b1) begin errors++; $display("FAIL rd_pre_ta got oe=%b in=%b exp 0 1", s_phy_oe[14], s_mdio_in[14]); end
    checks++; if (s_phy_oe[15] !== 1'b1 || s_mdio_in[15] !== 1'b0) begin errors++; $display("FAIL rd_ta got oe=%b in=%b exp 1 0", s_phy_oe[15], s_mdio_in[15]); end
    checks++; if (rd_word !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h exp beef", rd_word); end
    checks++; if (s_phy_oe[31] !== 1'b1) begin errors++; $display("FAIL rd_oe_e31 got %b exp 1", s_phy_oe[31]); end
    checks++; if (s_phy_oe[32] !== 1'b0 || s_mdio_in[32] !== 1'b1) begin errors++; $display("FAIL rd_release got oe=%b in=%b exp 0 1", s_phy_oe[32], s_mdio_in[32]); end
    checks++; if (s_wr_en !== 32'd0 || s_busy[32] !== 1'b0) begin errors++; $display("FAIL rd_end got wr=%h busy=%b exp 0 0", s_wr_en, s_busy[32]); end
  endtask

  task automatic test_wrong_phy();
    run_frame({2'b01, 2'b01, 5'd2, 5'd3, 2'b10, 16'h5A5A}, PRE, 33, 32);
    checks++; if (s_wr_en !== 32'd0 || s_rd_en !== 32'd0) begin errors++; $display("FAIL wp_strobes got wr=%h rd=%h exp 0", s_wr_en, s_rd_en); end
    checks++; if (s_phy_oe !== 32'd0) begin errors++; $display("FAIL wp_phy_oe got %h exp 0", s_phy_oe); end
    checks++; if (s_busy[31] !== 1'b1 || s_busy[32] !== 1'b0) begin errors++; $display("FAIL wp_busy got e31=%b e32=%b exp 1 0", s_busy[31], s_busy[32]); end
    checks++; if (s_wdata[32] !== 16'hA5C3) begin errors++; $display("FAIL wp_wdata got %h exp a5c3", s_wdata[32]); end
    run_frame({2'b01, 2'b01, 5'd1, 5'd7, 2'b10, 16'h1234}, PRE, 33, 32);
    checks++; if (s_wr_en[32] !== 1'b1 || s_wdata[32] !== 16'h1234 || s_addr[32] !== 5'd7) begin errors++; $display("FAIL wp_next got en=%b data=%h addr=%h exp 1 1234 07", s_wr_en[32], s_wdata[32], s_addr[32]); end
  endtask

  task automatic test_back_to_back();
    run_frame({2'b01, 2'b00, 5'd1, 5'd6, 18'h2AAAA}, PRE, 33, 32);
    checks++; if (s_wr_en !== 32'd0 || s_rd_en !== 32'd0 || s_phy_oe !== 32'd0) begin errors++; $display("FAIL b2b_op00 got wr=%h rd=%h oe=%h exp 0", s_wr_en, s_rd_en, s_phy_oe); end
    checks++; if (s_busy[32] !== 1'b0) begin errors++; $display("FAIL b2b_op00_busy got %b exp 0", s_busy[32]); end
    bus.reg_rd_data = 16'h1357;
    run_frame({2'b01, 2'b10, 5'd1, 5'd9, 18'h3FFFF}, PRE_B2B, 15, 32);
    collect_rd_word();
    checks++; if (s_rd_en[14] !== 1'b1 || s_addr[14] !== 5'd9) begin errors++; $display("FAIL b2b_rd_en got en=%b addr=%h exp 1 09", s_rd_en[14], s_addr[14]); end
    checks++; if (rd_word !== 16'h1357) begin errors++; $display("FAIL b2b_rd_data got %h exp 1357", rd_word); end
  endtask

  task automatic test_abort();
    run_frame({2'b01, 2'b01, 5'd1, 5'd4, 2'b10, 16'hFFFF}, PRE, 20, 32);
    checks++; if (s_busy[19] !== 1'b1 || s_busy[20] !== 1'b0) begin errors++; $display("FAIL ab_busy got e19=%b e20=%b exp 1 0", s_busy[19], s_busy[20]); end
    checks++; if (s_wr_en !== 32'd0) begin errors++; $display("FAIL ab_wr_en got %h exp 0", s_wr_en); end
    checks++; if (s_wdata[32] !== 16'h1234) begin errors++; $display("FAIL ab_wdata got %h exp 1234", s_wdata[32]); end
  endtask

  task automatic test_reset_mid_frame();
    bus.reg_rd_data = 16'hC0DE;
    run_frame({2'b01, 2'b10, 5'd1, 5'd2, 18'h3FFFF}, PRE, 15, 20);
    checks++; if (s_phy_oe[20] !== 1'b1) begin errors++; $display("FAIL rm_oe_before got %b exp 1", s_phy_oe[20]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.phy_oe !== 1'b0 || bus.mdio_in !== 1'b1) begin errors++; $display("FAIL rm_release got oe=%b in=%b exp 0 1", bus.phy_oe, bus.mdio_in); end
    checks++; if (bus.busy !== 1'b0 || bus.reg_addr !== 5'd0 || bus.reg_wr_data !== 16'h0) begin errors++; $display("FAIL rm_clear got busy=%b addr=%h wd=%h exp 0 0 0", bus.busy, bus.reg_addr, bus.reg_wr_data); end
    @(negedge clk); reset = 1'b1;
    run_frame({2'b01, 2'b01, 5'd1, 5'd10, 2'b10, 16'h0F0F}, PRE, 33, 25);
    #2 reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b0, 1'b1);
      checks++; if (bus.reg_wr_en !== 1'b0) begin errors++; $display("FAIL rm_wr_no_strobe got %b exp 0", bus.reg_wr_en); end
    end
    run_frame({2'b01, 2'b01, 5'd1, 5'd10, 2'b10, 16'h0F0F}, PRE, 33, 32);
    checks++; if (s_wr_en[32] !== 1'b1 || s_wdata[32] !== 16'h0F0F || s_addr[32] !== 5'd10) begin errors++; $display("FAIL rm_after got en=%b data=%h addr=%h exp 1 0f0f 0a", s_wr_en[32], s_wdata[32], s_addr[32]); end
  endtask

`ifdef MDIO_PREAMBLE_EN
  task automatic test_preamble();
    send_bit(1'b0, 1'b0);
    run_frame({2'b01, 2'b01, 5'd1, 5'd11, 2'b10, 16'h7777}, 31, 33, 32);
    checks++; if (s_wr_en !== 32'd0 || s_busy !== 32'd0) begin errors++; $display("FAIL pre31 got wr=%h busy=%h exp 0", s_wr_en, s_busy); end
    send_bit(1'b0, 1'b0);
    run_frame({2'b01, 2'b01, 5'd1, 5'd11, 2'b10, 16'h7777}, 32, 33, 32);
    checks++; if (s_wr_en[32] !== 1'b1 || s_wdata[32] !== 16'h7777) begin errors++; $display("FAIL pre32 got en=%b data=%h exp 1 7777", s_wr_en[32], s_wdata[32]); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_phy();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
`ifdef MDIO_PREAMBLE_EN
    test_preamble();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
